// File: rtl/gate_controller.sv
// ---------------------------------------------------------------------------
// gate_controller
//   Drives a gate (enable) to an external edge counter for gate_len cycles.
//   After the gate closes it waits for the counter to settle, then latches
//   count_in into result and holds it until the consumer accepts it.
//   Optional continuous mode re-arms a new gate right after each handshake.
//
// Ports
//   clk, rst        : clock, synchronous active-high reset
//   start           : begin a measurement (IDLE only)
//   abort           : cancel the current measurement from any state
//   continuous      : auto-restart after each result handshake
//   gate_len [W]    : gate length in cycles, sampled at every gate start
//   count_in [W]    : counter value, stable while enable is low
//   enable          : registered gate to the edge counter
//   result [W]      : last latched count
//   result_valid    : result pending, held until result_ready
//   result_ready    : consumer accept
//   busy            : FSM not in IDLE
//   meas_id [8]     : completed measurements, modulo 256
//   len_err         : one-cycle pulse on a start attempt with gate_len == 0
// ---------------------------------------------------------------------------
module gate_controller #(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned W             = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         abort,
    input  logic         continuous,
    input  logic [W-1:0] gate_len,
    input  logic [W-1:0] count_in,
    output logic         enable,
    output logic [W-1:0] result,
    output logic         result_valid,
    input  logic         result_ready,
    output logic         busy,
    output logic [7:0]   meas_id,
    output logic         len_err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GATE   = 2'd1,
        SETTLE = 2'd2,
        HOLD   = 2'd3
    } state_t;

    state_t       state_q;
    logic [W-1:0] cnt_q;        // gate down-counter, reused as settle counter
    logic         enable_q;
    logic [W-1:0] result_q;
    logic         valid_q;
    logic [7:0]   meas_id_q;
    logic         len_err_q;

    // Settle counter loads SETTLE_CYCLES and the capture happens on the edge
    // where it reads zero, so count_in is sampled only after SETTLE_CYCLES
    // full cycles have elapsed with enable low.
    localparam logic [W-1:0] SETTLE_LOAD = W'(SETTLE_CYCLES);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            enable_q  <= 1'b0;
            result_q  <= '0;
            valid_q   <= 1'b0;
            meas_id_q <= 8'd0;
            len_err_q <= 1'b0;
        end else begin
            len_err_q <= 1'b0;
            if (abort) begin
                // result and meas_id deliberately keep their values
                state_q  <= IDLE;
                enable_q <= 1'b0;
                valid_q  <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (start) begin
                            if (gate_len != '0) begin
                                cnt_q    <= gate_len;
                                enable_q <= 1'b1;
                                state_q  <= GATE;
                            end else begin
                                len_err_q <= 1'b1;
                            end
                        end
                    end
                    GATE: begin
                        // Counter holds the remaining high cycles including
                        // the current one; no wrap even for gate_len = all ones.
                        if (cnt_q == {{(W-1){1'b0}}, 1'b1}) begin
                            enable_q <= 1'b0;
                            cnt_q    <= SETTLE_LOAD;
                            state_q  <= SETTLE;
                        end else begin
                            cnt_q <= cnt_q - 1'b1;
                        end
                    end
                    SETTLE: begin
                        if (cnt_q == '0) begin
                            result_q  <= count_in;
                            valid_q   <= 1'b1;
                            meas_id_q <= meas_id_q + 8'd1;
                            state_q   <= HOLD;
                        end else begin
                            cnt_q <= cnt_q - 1'b1;
                        end
                    end
                    HOLD: begin
                        if (valid_q && result_ready) begin
                            valid_q <= 1'b0;
                            if (continuous && gate_len != '0) begin
                                cnt_q    <= gate_len;
                                enable_q <= 1'b1;
                                state_q  <= GATE;
                            end else begin
                                len_err_q <= continuous;
                                state_q   <= IDLE;
                            end
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign enable       = enable_q;
    assign result       = result_q;
    assign result_valid = valid_q;
    assign meas_id      = meas_id_q;
    assign len_err      = len_err_q;
    assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_gate_controller.sv
// ---------------------------------------------------------------------------
// tb_gate_controller
//   Directed bench for gate_controller (W=32, SETTLE_CYCLES=2). Inputs change
//   1 time unit after a rising edge; outputs are sampled at the same point.
// ---------------------------------------------------------------------------
module tb_gate_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic        continuous;
    logic [31:0] gate_len;
    logic [31:0] count_in;
    logic        enable;
    logic [31:0] result;
    logic        result_valid;
    logic        result_ready;
    logic        busy;
    logic [7:0]  meas_id;
    logic        len_err;

    int n_tests = 0;
    int n_fail  = 0;

    gate_controller #(.SETTLE_CYCLES(2), .W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .abort        (abort),
        .continuous   (continuous),
        .gate_len     (gate_len),
        .count_in     (count_in),
        .enable       (enable),
        .result       (result),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .busy         (busy),
        .meas_id      (meas_id),
        .len_err      (len_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_en"},  32'(enable),       32'd0);
        chk({tag, "_rv"},  32'(result_valid), 32'd0);
        chk({tag, "_bsy"}, 32'(busy),         32'd0);
        chk({tag, "_res"}, result,            32'd0);
        chk({tag, "_id"},  32'(meas_id),      32'd0);
        chk({tag, "_le"},  32'(len_err),      32'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; continuous = 1'b0;
        gate_len = 32'd0; count_in = 32'd0; result_ready = 1'b0;
        tick(); tick();
        chk_reset_vals("reset");
        rst = 1'b0;
        tick();

        // Basic measurement: gate_len 5, count_in 123
        gate_len = 32'd5; count_in = 32'd123; start = 1'b1;
        tick();
        start = 1'b0;
        gate_len = 32'd9;               // must not affect running gate
        chk("g5_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 5; i++) begin
            chk("g5_en_hi", 32'(enable), 32'd1);
            if (i == 1) start = 1'b1;   // ignored outside IDLE
            if (i == 2) start = 1'b0;
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            chk("g5_settle_en", 32'(enable), 32'd0);
            chk("g5_settle_rv", 32'(result_valid), 32'd0);
            tick();
        end
        chk("g5_rv",  32'(result_valid), 32'd1);
        chk("g5_res", result, 32'd123);
        chk("g5_id",  32'(meas_id), 32'd1);
        count_in = 32'd7;
        start = 1'b1;                   // ignored in HOLD
        for (int i = 0; i < 10; i++) begin
            tick();
            if (i == 0) start = 1'b0;
            chk("hold_rv",  32'(result_valid), 32'd1);
            chk("hold_res", result, 32'd123);
            chk("hold_en",  32'(enable), 32'd0);
        end
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        chk("hs_rv",   32'(result_valid), 32'd0);
        chk("hs_busy", 32'(busy), 32'd0);
        chk("hs_res",  result, 32'd123);
        tick();
        chk("no_queue_busy", 32'(busy), 32'd0);

        // Zero-length start
        gate_len = 32'd0; start = 1'b1;
        tick();
        start = 1'b0;
        chk("len0_le",   32'(len_err), 32'd1);
        chk("len0_en",   32'(enable), 32'd0);
        chk("len0_busy", 32'(busy), 32'd0);
        tick();
        chk("len0_le_pulse", 32'(len_err), 32'd0);
        chk("len0_id",       32'(meas_id), 32'd1);

        // Abort on gate cycle 2 with start high
        gate_len = 32'd10; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("ab_pre_en", 32'(enable), 32'd1);
        abort = 1'b1; start = 1'b1;
        tick();
        abort = 1'b0; start = 1'b0;
        chk("ab_en",   32'(enable), 32'd0);
        chk("ab_busy", 32'(busy), 32'd0);
        chk("ab_rv",   32'(result_valid), 32'd0);
        chk("ab_id",   32'(meas_id), 32'd1);
        chk("ab_res",  result, 32'd123);
        for (int i = 0; i < 6; i++) tick();
        chk("ab_later_rv", 32'(result_valid), 32'd0);

        // Reset mid-GATE
        gate_len = 32'd4; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_reset_vals("rst_gate");
        for (int i = 0; i < 8; i++) tick();
        chk("rst_gate_norv", 32'(result_valid), 32'd0);

        // Reset in SETTLE
        gate_len = 32'd2; count_in = 32'd44; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        chk("pre_settle_en", 32'(enable), 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_reset_vals("rst_settle");

        // Reset in HOLD
        gate_len = 32'd1; count_in = 32'd55; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("g1_rv",  32'(result_valid), 32'd1);
        chk("g1_res", result, 32'd55);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_reset_vals("rst_hold");

        // Normal measurement after reset
        gate_len = 32'd2; count_in = 32'd77; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("post_rst_rv",  32'(result_valid), 32'd1);
        chk("post_rst_res", result, 32'd77);
        chk("post_rst_id",  32'(meas_id), 32'd1);
        result_ready = 1'b1;
        tick();
        chk("post_rst_busy", 32'(busy), 32'd0);

        // Continuous mode, gate_len 3, 257 measurements from meas_id 0
        rst = 1'b1;
        tick();
        rst = 1'b0;
        continuous = 1'b1; gate_len = 32'd3; result_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int m = 1; m <= 257; m++) begin
            count_in = 32'(m * 3);
            for (int c = 0; c < 3; c++) begin
                chk("cont_en_hi", 32'(enable), 32'd1);
                tick();
            end
            for (int c = 0; c < 4; c++) begin
                chk("cont_en_lo", 32'(enable), 32'd0);
                tick_if_not_last(c);
            end
            chk("cont_rv",  32'(result_valid), 32'd1);
            chk("cont_res", result, 32'(m * 3));
            chk("cont_id",  32'(meas_id), 32'(m % 256));
            tick();
        end
        chk("cont_wrap_id", 32'(meas_id), 32'd1);
        chk("cont_regate",  32'(enable), 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0; continuous = 1'b0;
        chk("cont_abort_en",   32'(enable), 32'd0);
        chk("cont_abort_busy", 32'(busy), 32'd0);
        chk("cont_abort_id",   32'(meas_id), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // The fourth low cycle is the HOLD cycle, checked in the caller before
    // its own tick, so only the first three low cycles advance here.
    task automatic tick_if_not_last(input int c);
        if (c < 3) tick();
    endtask

endmodule
